// File: rtl/park_gate_controller.sv
// Barrier-lane sequencer: arbitrates entry/exit, runs open/pass/close, pulses car_in/car_out once per passage.
// All outputs registered; request-to-gate 2 edges. PARK_GATE_TIMEOUT_EN enables PASSING abort after PASS_TIMEOUT cycles.
module park_gate_controller #(
  parameter int CAPACITY     = 12,
  parameter int OPEN_CYCLES  = 4,
  parameter int PASS_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_in,
  input  logic       req_out,
  input  logic       pass_done,
  input  logic [3:0] car_count,
  output logic       gate_open,
  output logic       dir_in,
  output logic       busy,
  output logic       car_in,
  output logic       car_out,
  output logic       reject,
  output logic       timeout
);

  localparam int TMAX = (OPEN_CYCLES > PASS_TIMEOUT) ? OPEN_CYCLES : PASS_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
`ifdef PARK_GATE_TIMEOUT_EN
  localparam logic [TW-1:0] PASS_LOAD = TW'(PASS_TIMEOUT - 1);
`else
  localparam logic [TW-1:0] PASS_LOAD = '0;
`endif

  typedef enum logic [1:0] {IDLE, OPENING, PASSING, CLOSING} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          pend_in, pend_in_nxt;
  logic          pend_out, pend_out_nxt;
  logic          last_dir, last_dir_nxt;
  logic          dir_nxt;
  logic          car_in_nxt, car_out_nxt, reject_nxt;
  logic          in_room;
`ifdef PARK_GATE_TIMEOUT_EN
  logic          timeout_nxt;
`endif

  assign in_room = ({1'b0, car_count} < 5'(CAPACITY));

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    dir_nxt      = dir_in;
    last_dir_nxt = last_dir;
    car_in_nxt   = 1'b0;
    car_out_nxt  = 1'b0;
    reject_nxt   = 1'b0;
`ifdef PARK_GATE_TIMEOUT_EN
    timeout_nxt  = 1'b0;
`endif
    // A direction currently holding the lane does not re-arm its own pending flag.
    pend_in_nxt  = pend_in  | (req_in  & ~((state != IDLE) &  dir_in));
    pend_out_nxt = pend_out | (req_out & ~((state != IDLE) & ~dir_in));

    unique case (state)
      IDLE: begin
        if (pend_in && !in_room) begin
          reject_nxt  = 1'b1;
          pend_in_nxt = 1'b0;
        end else if (pend_in && (!pend_out || !last_dir)) begin
          state_nxt   = OPENING;
          timer_nxt   = OPEN_LOAD;
          dir_nxt     = 1'b1;
          pend_in_nxt = 1'b0;
        end else if (pend_out) begin
          state_nxt    = OPENING;
          timer_nxt    = OPEN_LOAD;
          dir_nxt      = 1'b0;
          pend_out_nxt = 1'b0;
        end
      end
      OPENING: begin
        if (timer == '0) begin
          state_nxt = PASSING;
          timer_nxt = PASS_LOAD;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      PASSING: begin
        if (pass_done) begin
          car_in_nxt   = dir_in;
          car_out_nxt  = ~dir_in;
          last_dir_nxt = dir_in;
          state_nxt    = CLOSING;
          timer_nxt    = OPEN_LOAD;
        end
`ifdef PARK_GATE_TIMEOUT_EN
        else if (timer == '0) begin
          timeout_nxt = 1'b1;
          state_nxt   = CLOSING;
          timer_nxt   = OPEN_LOAD;
        end else begin
          timer_nxt = timer - TW'(1);
        end
`endif
      end
      CLOSING: begin
        if (timer == '0) state_nxt = IDLE;
        else             timer_nxt = timer - TW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      timer     <= '0;
      pend_in   <= 1'b0;
      pend_out  <= 1'b0;
      last_dir  <= 1'b0;
      dir_in    <= 1'b0;
      gate_open <= 1'b0;
      busy      <= 1'b0;
      car_in    <= 1'b0;
      car_out   <= 1'b0;
      reject    <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      pend_in   <= pend_in_nxt;
      pend_out  <= pend_out_nxt;
      last_dir  <= last_dir_nxt;
      dir_in    <= dir_nxt;
      gate_open <= (state_nxt == OPENING) || (state_nxt == PASSING);
      busy      <= (state_nxt != IDLE);
      car_in    <= car_in_nxt;
      car_out   <= car_out_nxt;
      reject    <= reject_nxt;
    end
  end

`ifdef PARK_GATE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) timeout <= 1'b0;
    else      timeout <= timeout_nxt;
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_park_gate_controller.sv
// Directed bench for park_gate_controller: grant/pass/close timing, full refusal, tie arbitration, reset abort.
module tb_park_gate_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_in = 1'b0, req_out = 1'b0, pass_done = 1'b0;
  logic [3:0] car_count = 4'd0;
  logic       gate_open, dir_in, busy, car_in, car_out, reject, timeout;

  int n_chk = 0;
  int n_err = 0;

  park_gate_controller #(.CAPACITY(12), .OPEN_CYCLES(4), .PASS_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .req_out(req_out), .pass_done(pass_done),
    .car_count(car_count), .gate_open(gate_open), .dir_in(dir_in), .busy(busy),
    .car_in(car_in), .car_out(car_out), .reject(reject), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_gate"},    gate_open, 1'b0);
    check_eq({tag, "_busy"},    busy,      1'b0);
    check_eq({tag, "_car_in"},  car_in,    1'b0);
    check_eq({tag, "_car_out"}, car_out,   1'b0);
    check_eq({tag, "_reject"},  reject,    1'b0);
    check_eq({tag, "_timeout"}, timeout,   1'b0);
  endtask

  // Called right after a grant edge g: pass_done raised in PASSING, sampled at g+6.
  task automatic pass_through(input logic exp_dir, input string tag);
    check_eq({tag, "_busy"}, busy, 1'b1);
    check_eq({tag, "_dir"},  dir_in, exp_dir);
    check_eq({tag, "_gate"}, gate_open, 1'b1);
    tick(5);
    pass_done = 1'b1;
    tick(1);
    pass_done = 1'b0;
    check_eq({tag, "_car_in"},  car_in,  exp_dir);
    check_eq({tag, "_car_out"}, car_out, ~exp_dir);
    check_eq({tag, "_gate_fall"}, gate_open, 1'b0);
    tick(1);
    check_eq({tag, "_car_in_once"},  car_in,  1'b0);
    check_eq({tag, "_car_out_once"}, car_out, 1'b0);
    tick(3);
    check_eq({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    // Reset state
    tick(2);
    check_idle_outputs("rst");
    check_eq("rst_dir", dir_in, 1'b0);
    rst = 1'b1;
    tick(1);

    // Entry grant, car_count=3, explicit closing length
    car_count = 4'd3;
    req_in = 1'b1;
    tick(1);
    req_in = 1'b0;
    check_eq("t1_not_yet_busy", busy, 1'b0);
    check_eq("t1_not_yet_gate", gate_open, 1'b0);
    tick(1);
    check_eq("t1_busy", busy, 1'b1);
    check_eq("t1_gate", gate_open, 1'b1);
    check_eq("t1_dir", dir_in, 1'b1);
    tick(5);
    check_eq("t1_passing_gate", gate_open, 1'b1);
    pass_done = 1'b1;
    tick(1);
    pass_done = 1'b0;
    check_eq("t1_car_in", car_in, 1'b1);
    check_eq("t1_car_out", car_out, 1'b0);
    check_eq("t1_gate_fall", gate_open, 1'b0);
    tick(1);
    check_eq("t1_car_in_once", car_in, 1'b0);
    tick(2);
    check_eq("t1_closing_busy", busy, 1'b1);
    tick(1);
    check_eq("t1_idle", busy, 1'b0);

    // Full refusal at car_count=12
    car_count = 4'd12;
    req_in = 1'b1;
    tick(1);
    req_in = 1'b0;
    check_eq("t2_no_reject_yet", reject, 1'b0);
    tick(1);
    check_eq("t2_reject", reject, 1'b1);
    check_eq("t2_busy", busy, 1'b0);
    check_eq("t2_gate", gate_open, 1'b0);
    tick(1);
    check_eq("t2_reject_once", reject, 1'b0);
    check_eq("t2_busy_after", busy, 1'b0);

    // Tie after reset at car_count=11 (one below capacity): entry first, then exit
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    car_count = 4'd11;
    req_in = 1'b1;
    req_out = 1'b1;
    tick(1);
    req_in = 1'b0;
    req_out = 1'b0;
    tick(1);
    pass_through(1'b1, "t3_tie_entry");
    tick(1);
    check_eq("t3_exit_busy", busy, 1'b1);
    check_eq("t3_exit_dir", dir_in, 1'b0);
    // pass_done held from the grant: ignored through OPENING, taken on the first PASSING edge
    pass_done = 1'b1;
    tick(4);
    check_eq("t3_open_len_no_pulse", car_out, 1'b0);
    check_eq("t3_open_len_gate", gate_open, 1'b1);
    tick(1);
    pass_done = 1'b0;
    check_eq("t3_car_out", car_out, 1'b1);
    check_eq("t3_car_in_low", car_in, 1'b0);
    tick(4);
    check_eq("t3_idle", busy, 1'b0);

    // Entry alone makes entry the last-served direction; next tie goes to exit
    req_in = 1'b1;
    tick(1);
    req_in = 1'b0;
    tick(1);
    pass_through(1'b1, "t4_entry");
    req_in = 1'b1;
    req_out = 1'b1;
    tick(1);
    req_in = 1'b0;
    req_out = 1'b0;
    tick(1);
    pass_through(1'b0, "t4_tie_exit");
    tick(1);
    pass_through(1'b1, "t4_then_entry");

    // Exit request arriving during an entry PASSING is served after CLOSING
    req_in = 1'b1;
    tick(1);
    req_in = 1'b0;
    tick(1);
    check_eq("t5_dir", dir_in, 1'b1);
    tick(5);
    req_out = 1'b1;
    tick(1);
    req_out = 1'b0;
    pass_done = 1'b1;
    tick(1);
    pass_done = 1'b0;
    check_eq("t5_car_in", car_in, 1'b1);
    check_eq("t5_no_car_out", car_out, 1'b0);
    tick(4);
    check_eq("t5_idle", busy, 1'b0);
    tick(1);
    pass_through(1'b0, "t5_exit");

`ifdef PARK_GATE_TIMEOUT_EN
    // Abort 16 cycles into PASSING with no count pulse
    req_in = 1'b1;
    tick(1);
    req_in = 1'b0;
    tick(1);
    tick(19);
    check_eq("t7_no_timeout_yet", timeout, 1'b0);
    check_eq("t7_still_open", gate_open, 1'b1);
    tick(1);
    check_eq("t7_timeout", timeout, 1'b1);
    check_eq("t7_no_car_in", car_in, 1'b0);
    check_eq("t7_gate_fall", gate_open, 1'b0);
    tick(1);
    check_eq("t7_timeout_once", timeout, 1'b0);
    tick(3);
    check_eq("t7_idle", busy, 1'b0);
`endif

    // Reset mid-PASSING drops the passage and the queued exit request
    req_in = 1'b1;
    tick(1);
    req_in = 1'b0;
    tick(6);
    req_out = 1'b1;
    tick(1);
    req_out = 1'b0;
    check_eq("t6_passing", gate_open, 1'b1);
    #2;
    rst = 1'b0;
    pass_done = 1'b1;
    #1;
    check_idle_outputs("t6_async");
    tick(2);
    rst = 1'b1;
    pass_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check_eq("t6_no_grant", busy, 1'b0);
      check_eq("t6_no_pulse", car_in | car_out, 1'b0);
    end
    req_out = 1'b1;
    tick(1);
    req_out = 1'b0;
    tick(1);
    pass_through(1'b0, "t6_new_exit");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/park_gate_controller.md
# park_gate_controller

Sequencing controller for the single shared barrier lane of the car park. Arbitrates entry and exit vehicle requests, runs each granted vehicle through an open/pass/close gate cycle, and emits exactly one single-cycle `car_in` or `car_out` pulse per completed passage. These pulses drive the car counter and floor FSM. Entry is refused when the counter reports the park at capacity.

## Interface

Parameters:
- `CAPACITY`, 12: number of spots. An entry is granted only if `car_count < CAPACITY`.
- `OPEN_CYCLES`, 4: gate travel time in cycles, used for both opening and closing.
- `PASS_TIMEOUT`, 16: maximum cycles spent in PASSING before abort (only with the macro, see Configuration).

Ports:
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `req_in`, in, 1: entry-loop sensor, level.
- `req_out`, in, 1: exit-loop sensor, level.
- `pass_done`, in, 1: beam cleared by the vehicle, level, sampled only in PASSING.
- `car_count`, in, 4: current occupancy from the counter.
- `gate_open`, out, 1: barrier drive (1 = raise or hold up).
- `dir_in`, out, 1: direction of the current grant (1 = entry). Valid while `busy`.
- `busy`, out, 1: high in every state except IDLE.
- `car_in`, out, 1: one-cycle pulse when an entry passage completes.
- `car_out`, out, 1: one-cycle pulse when an exit passage completes.
- `reject`, out, 1: one-cycle pulse when an entry is refused because the park is full.
- `timeout`, out, 1: one-cycle pulse when a passage is aborted.

## Operation

- Pending flags `pend_in` and `pend_out`:
  - Set on any edge where the matching request is high and that direction is not currently being served.
  - Cleared on grant.
  - Requests arriving while busy stay pending.
- States: IDLE, OPENING, PASSING, CLOSING.
- IDLE arbitration, evaluated each edge:
  - Entry candidate: `pend_in` is set and `car_count < CAPACITY`.
  - If `pend_in` is set but the park is full: clear `pend_in`, pulse `reject`, stay IDLE.
  - Both candidates valid: the direction not served last wins. `last_dir` resets to exit, so entry wins the first tie.
  - Single candidate: grant it.
  - On grant: go to OPENING, latch `dir_in`, load timer with `OPEN_CYCLES-1`, clear that pending flag.
- OPENING: `gate_open=1`. Timer decrements each cycle; at 0 go to PASSING and reload the timer.
- PASSING: `gate_open=1`.
  - On `pass_done=1`: pulse `car_in` (if `dir_in`) or `car_out`, update `last_dir`, go to CLOSING.
  - With the timeout feature, if the timer expires first: pulse `timeout`, no count pulse, go to CLOSING.
- CLOSING: `gate_open=0` for `OPEN_CYCLES` cycles, then IDLE. Requests are not granted during CLOSING.
- `car_in` and `car_out` are never high together, and never more than once per grant.
- Timer width is `$clog2(max(OPEN_CYCLES, PASS_TIMEOUT)+1)`. The timer saturates at 0 and never wraps.

## Timing

- Reset (asynchronous, `rst=0`):
  - State is IDLE.
  - All outputs are 0.
  - Pending flags are 0.
  - Timer is 0.
  - `last_dir` is exit.
  - Reset mid-passage drops the passage silently, with no count pulse.
- `req_in` high at edge k sets `pend_in` at k. The grant takes effect at edge k+1 (`busy=1`, `gate_open=1`). Request-to-gate latency is 2 edges.
- `gate_open` is high for exactly `OPEN_CYCLES` cycles in OPENING, then for the whole PASSING dwell.
- `pass_done` sampled high at edge p: the count pulse is high for cycle p to p+1 and `gate_open` falls at p.
- Earliest next grant: `OPEN_CYCLES` cycles after entering CLOSING, then one IDLE edge.
- The full check uses the `car_count` sampled at the grant edge. The count pulse of a finishing passage is visible to the counter before the next grant.
- All outputs are registered.

## Configuration

- `PARK_GATE_TIMEOUT_EN` defined:
  - PASSING aborts after `PASS_TIMEOUT` cycles without `pass_done`.
  - On abort: `timeout` pulses and the FSM goes to CLOSING with no `car_in`/`car_out`.
- Not defined:
  - PASSING waits indefinitely for `pass_done`.
  - `timeout` is tied to 0.
  - `PASS_TIMEOUT` is unused.

## Test plan

- Entry grant, `car_count=3`: `req_in` for 1 cycle → `gate_open` high 2 edges later, `busy=1`, `dir_in=1`. Raise `pass_done` after 6 cycles → `car_in` pulses exactly 1 cycle, 4 closed cycles follow, then IDLE.
- Full refusal, `car_count=12`: `req_in` → one `reject` pulse, `gate_open` stays 0, `busy` stays 0.
- Tie after reset: `req_in` and `req_out` high on the same edge → entry served first, then exit served after CLOSING. Repeat the tie → exit served first.
- Request while busy: `req_out` pulsed during an entry PASSING → exit granted right after CLOSING, with one `car_out` pulse.
- Timeout (macro on, `PASS_TIMEOUT=16`): grant with no `pass_done` → `timeout` pulses 16 cycles into PASSING, and no `car_in`/`car_out` appears.
- Reset mid-PASSING: drive `rst` low → all outputs 0 immediately, no count pulse. After release, only new requests are granted.
